// File: rtl/memShare_config_pkg.sv
// memShare_config_pkg: shared DRC constants, FSM states and DRC decode for the memShare address generator
package memShare_config_pkg;
  localparam int MEMSHARE_DRC_NUM = 3;
  localparam int DRC1_IDX = 0;
  localparam int DRC2_IDX = 1;
  localparam int DRC3_IDX = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  function automatic logic excl_drc1(input logic [MEMSHARE_DRC_NUM-1:0] drc);
    return drc[DRC1_IDX] & ~drc[DRC2_IDX] & ~drc[DRC3_IDX];
  endfunction
endpackage

// File: rtl/memshare_rqst_addr_lane.sv
// memshare_rqst_addr_lane: one request-address channel with wrap, DRC1 rebase and beat/rebase counters
module memshare_rqst_addr_lane
  import memShare_config_pkg::*;
#(
  parameter int ADDR_WIDTH    = 6,
  parameter int ADDR_BASE     = 0,
  parameter int ADDR_DEPTH    = 48,
  parameter int REBASE_OFFSET = 16,
  parameter int LEN_WIDTH     = 6
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        start_i,
  input  logic [LEN_WIDTH-1:0]        start_len_i,
  input  logic [LEN_WIDTH-1:0]        len_i,
  input  logic                        rebase_en_i,
  input  logic [MEMSHARE_DRC_NUM-1:0] drc_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic                        valid_d_o,
  output logic [ADDR_WIDTH-1:0]       addr_o,
  output logic [ADDR_WIDTH-1:0]       operand_o,
  output logic [LEN_WIDTH-1:0]        rebase_cnt_o
);
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(ADDR_BASE);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(ADDR_BASE + ADDR_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] RB   = ADDR_WIDTH'(ADDR_BASE + REBASE_OFFSET);
  logic                  hs, rb, valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, op_q, op_d, nxt;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d, cnt_q, cnt_d;
  always_comb begin
    hs      = valid_q & ready_i;
    rb      = rebase_en_i & excl_drc1(drc_i);
    nxt     = rb ? RB : (addr_q == LAST) ? BASE : addr_q + ADDR_WIDTH'(1);
    addr_d  = start_i ? BASE : hs ? nxt : addr_q;
    op_d    = start_i ? '0 : hs ? nxt - addr_q : op_q;
    beat_d  = start_i ? '0 : hs ? beat_q + LEN_WIDTH'(1) : beat_q;
    cnt_d   = start_i ? '0 : (hs && rb && !(&cnt_q)) ? cnt_q + LEN_WIDTH'(1) : cnt_q;
    valid_d = start_i ? (start_len_i != '0) :
              (hs && (beat_q + LEN_WIDTH'(1) == len_i)) ? 1'b0 : valid_q;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= BASE;
      op_q    <= '0;
      beat_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      beat_q  <= beat_d;
      cnt_q   <= cnt_d;
    end
  end
  assign valid_o      = valid_q;
  assign valid_d_o    = valid_d;
  assign addr_o       = addr_q;
  assign operand_o    = op_q;
  assign rebase_cnt_o = cnt_q;
endmodule

// File: rtl/memshare_rqst_addr_gen.sv
// memshare_rqst_addr_gen: multi-channel memShare request-address generator with run-control FSM
module memshare_rqst_addr_gen
  import memShare_config_pkg::*;
#(
  parameter int CH_NUM        = 4,
  parameter int ADDR_WIDTH    = 6,
  parameter int ADDR_BASE     = 0,
  parameter int ADDR_DEPTH    = 48,
  parameter int REBASE_OFFSET = 16,
  parameter int LEN_WIDTH     = 6
) (
  input  logic                               sys_clk,
  input  logic                               rst,
  input  logic                               scu_begin_i,
  input  logic [LEN_WIDTH-1:0]               rqst_len_i,
  input  logic                               rebase_en_i,
  input  logic [CH_NUM*MEMSHARE_DRC_NUM-1:0] is_drc_i,
  input  logic [CH_NUM-1:0]                  rqst_ready_i,
  output logic [CH_NUM-1:0]                  rqst_valid_o,
  output logic [CH_NUM*ADDR_WIDTH-1:0]       rqst_addr_o,
  output logic [CH_NUM*ADDR_WIDTH-1:0]       incr_operand_o,
  output logic [CH_NUM*LEN_WIDTH-1:0]        rebase_cnt_o,
  output logic                               busy_o,
  output logic                               done_o
);
  state_e               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic                 ren_q, ren_d, busy_q, busy_d, done_q, done_d;
  logic [CH_NUM-1:0]    act;
  // a lane's next valid is low exactly once it has taken its last beat, so the OR flags pending work
  always_comb begin
    state_d = ST_IDLE;
    if (scu_begin_i) state_d = (rqst_len_i == '0) ? ST_DONE : ST_RUN;
    else if (state_q == ST_RUN) state_d = |act ? ST_RUN : ST_DONE;
    len_d  = scu_begin_i ? rqst_len_i : len_q;
    ren_d  = scu_begin_i ? rebase_en_i : ren_q;
    busy_d = state_d == ST_RUN;
    done_d = state_d == ST_DONE;
  end
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      ren_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      ren_q   <= ren_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign busy_o = busy_q;
  assign done_o = done_q;
  for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
    memshare_rqst_addr_lane #(
      .ADDR_WIDTH   (ADDR_WIDTH),
      .ADDR_BASE    (ADDR_BASE),
      .ADDR_DEPTH   (ADDR_DEPTH),
      .REBASE_OFFSET(REBASE_OFFSET),
      .LEN_WIDTH    (LEN_WIDTH)
    ) u_lane (
      .sys_clk     (sys_clk),
      .rst         (rst),
      .start_i     (scu_begin_i),
      .start_len_i (rqst_len_i),
      .len_i       (len_q),
      .rebase_en_i (ren_q),
      .drc_i       (is_drc_i[g*MEMSHARE_DRC_NUM +: MEMSHARE_DRC_NUM]),
      .ready_i     (rqst_ready_i[g]),
      .valid_o     (rqst_valid_o[g]),
      .valid_d_o   (act[g]),
      .addr_o      (rqst_addr_o[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .operand_o   (incr_operand_o[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .rebase_cnt_o(rebase_cnt_o[g*LEN_WIDTH +: LEN_WIDTH])
    );
  end
endmodule

// File: tb/tb_memshare_rqst_addr_gen.sv
// tb_memshare_rqst_addr_gen: directed scoreboard bench for the memShare request-address generator
module tb_memshare_rqst_addr_gen;
  logic        clk = 0;
  logic        rst, scu_begin, ren, busy, done;
  logic [5:0]  len;
  logic [11:0] drc;
  logic [3:0]  ready, valid;
  logic [23:0] addr, op, rcnt;
  logic [11:0] sb [4][$];
  int          nchk = 0, nfail = 0, dones = 0;
  int          hs [4];

  memshare_rqst_addr_gen dut (
    .sys_clk(clk), .rst(rst), .scu_begin_i(scu_begin), .rqst_len_i(len),
    .rebase_en_i(ren), .is_drc_i(drc), .rqst_ready_i(ready), .rqst_valid_o(valid),
    .rqst_addr_o(addr), .incr_operand_o(op), .rebase_cnt_o(rcnt),
    .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [11:0] e;
    if (done) dones++;
    for (int c = 0; c < 4; c++) begin
      if (valid[c] && ready[c]) begin
        hs[c]++;
        if (sb[c].size() == 0) chk($sformatf("extra_beat_ch%0d", c), 1, 0);
        else begin
          e = sb[c].pop_front();
          chk($sformatf("addr_ch%0d", c), int'(addr[c*6 +: 6]), int'(e[11:6]));
          chk($sformatf("oper_ch%0d", c), int'(op[c*6 +: 6]), int'(e[5:0]));
        end
      end
    end
  end

  task automatic push(input int c, input int a, input int o);
    sb[c].push_back({6'(a), 6'(o)});
  endtask

  task automatic push_lin(input int c, input int n);
    for (int i = 0; i < n; i++) push(c, i % 48, (i == 0) ? 0 : ((i % 48 == 0) ? 17 : 1));
  endtask

  task automatic start(input int n, input bit re);
    scu_begin = 1; len = 6'(n); ren = re;
    for (int c = 0; c < 4; c++) hs[c] = 0;
    dones = 0;
    tick();
    scu_begin = 0;
  endtask

  task automatic sb_empty(input string n);
    for (int c = 0; c < 4; c++) chk($sformatf("%s_left_ch%0d", n, c), sb[c].size(), 0);
  endtask

  task automatic chk_reset(input string n);
    chk({n, "_valid"}, int'(valid), 0);
    chk({n, "_addr"}, int'(addr), 0);
    chk({n, "_oper"}, int'(op), 0);
    chk({n, "_rcnt"}, int'(rcnt), 0);
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
  endtask

  // drives per-edge ready/DRC stimulus after start until done_o or the budget runs out
  task automatic go(input string n, input int l, input bit re, input int dcyc,
                    input logic [11:0] dval, input bit tog, input int lat, input logic [23:0] rc);
    int k;
    bit seen;
    ready = 4'hF;
    start(l, re);
    seen = 0;
    for (k = 1; k <= 300; k++) begin
      ready[1] = tog ? k[0] : 1'b1;
      drc = (k == dcyc) ? dval : 12'h000;
      tick();
      if (done) begin
        seen = 1;
        break;
      end
    end
    drc = 0;
    chk({n, "_done_seen"}, int'(seen), 1);
    chk({n, "_latency"}, k, lat);
    chk({n, "_busy_at_done"}, int'(busy), 0);
    chk({n, "_ch1_beats"}, hs[1], l);
    tick();
    chk({n, "_done_pulse"}, int'(done), 0);
    chk({n, "_rcnt"}, int'(rcnt), int'(rc));
    sb_empty(n);
  endtask

  initial begin
    rst = 1; scu_begin = 0; len = 0; ren = 0; drc = 0; ready = 0;
    tick(); tick();
    chk_reset("reset");
    rst = 0;
    dones = 0;
    repeat (3) tick();
    chk("reset_no_done", dones, 0);

    for (int c = 0; c < 4; c++) push_lin(c, 5);
    go("linear", 5, 0, 0, 0, 0, 5, 0);

    push(0, 0, 0); push(0, 1, 1); push(0, 16, 15); push(0, 17, 1);
    for (int c = 1; c < 4; c++) push_lin(c, 4);
    go("rebase", 4, 1, 2, 12'h001, 0, 4, 24'h000001);

    for (int c = 0; c < 4; c++) push_lin(c, 4);
    go("nonexcl", 4, 1, 2, 12'h003, 0, 4, 0);
    for (int c = 0; c < 4; c++) push_lin(c, 4);
    go("rb_off", 4, 0, 2, 12'h001, 0, 4, 0);

    for (int c = 0; c < 4; c++) push_lin(c, 50);
    go("wrap", 50, 0, 0, 0, 1, 99, 0);

    start(0, 0);
    chk("zero_done", int'(done), 1);
    chk("zero_valid", int'(valid), 0);
    chk("zero_busy", int'(busy), 0);
    tick();
    chk("zero_done_pulse", int'(done), 0);

    for (int c = 0; c < 4; c++) begin push_lin(c, 3); push_lin(c, 2); end
    ready = 4'hF;
    start(5, 0);
    repeat (3) tick();
    ready = 0;
    start(2, 0);
    chk("restart_addr", int'(addr), 0);
    chk("restart_oper", int'(op), 0);
    chk("restart_valid", int'(valid), 15);
    chk("restart_busy", int'(busy), 1);
    ready = 4'hF;
    tick();
    chk("restart_early_done", int'(done), 0);
    tick();
    chk("restart_done", int'(done), 1);
    chk("restart_done_cnt", dones, 0);
    tick();
    sb_empty("restart");

    for (int c = 0; c < 4; c++) push_lin(c, 3);
    start(5, 0);
    repeat (3) tick();
    ready = 0; rst = 1;
    tick();
    chk_reset("midrst");
    rst = 0; ready = 4'hF;
    repeat (8) tick();
    chk("midrst_no_done", dones, 0);
    chk("midrst_valid", int'(valid), 0);
    sb_empty("midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/memshare_rqst_addr_gen.md
# memshare_rqst_addr_gen

Multi-channel request-address generator for the message-passing buffer during the SCU.memShare() period. It issues `CH_NUM` independent streams of read addresses, each under a valid/ready handshake. Each stream rebases to a fixed offset when an exclusive-DRC1 condition is reported on an accepted beat. It also exports the adder operand that produced each address and per-channel rebase counts. It sits between the memShare scheduler (the source of `scu_begin_i`, lengths and DRC flags) and the message-passing buffer read port.

## Interface
Parameters:
- `CH_NUM`, 4, number of independent address channels
- `ADDR_WIDTH`, 6, request address / operand width
- `ADDR_BASE`, 0, first address of every run; wrap target
- `ADDR_DEPTH`, 48, addresses per window; last valid address is `ADDR_BASE+ADDR_DEPTH-1`
- `REBASE_OFFSET`, 16, rebase target is `ADDR_BASE+REBASE_OFFSET`; must be `< ADDR_DEPTH`
- `LEN_WIDTH`, 6, width of run length and rebase counters

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `scu_begin_i`  in  1  one-cycle start of SCU.memShare(); samples `rqst_len_i` and `rebase_en_i`
- `rqst_len_i`  in  LEN_WIDTH  beats per channel for this run
- `rebase_en_i`  in  1  1 = DRC rebasing on, 0 = strictly linear addressing
- `is_drc_i`  in  CH_NUM×MEMSHARE_DRC_NUM  per-channel DRC flags, qualifying the beat accepted this cycle
- `rqst_ready_i`  in  CH_NUM  downstream ready per channel
- `rqst_valid_o`  out  CH_NUM  address valid per channel
- `rqst_addr_o`  out  CH_NUM×ADDR_WIDTH  current request address per channel
- `incr_operand_o`  out  CH_NUM×ADDR_WIDTH  operand that produced the current address from the previous one
- `rebase_cnt_o`  out  CH_NUM×LEN_WIDTH  rebases taken in the current run
- `busy_o`  out  1  high in RUN
- `done_o`  out  1  one-cycle pulse at end of run

## Operation
- FSM has three states: IDLE, RUN, DONE.
  - IDLE goes to RUN on `scu_begin_i`. If the sampled length is 0, IDLE goes to DONE instead.
  - RUN goes to DONE when every channel has completed `len` handshakes.
  - DONE goes to IDLE unconditionally after one cycle.
- On `scu_begin_i`, every channel loads addr=`ADDR_BASE`, operand=0, beat count=0 and rebase_cnt=0.
- A handshake fires on channel c when `rqst_valid_o[c] && rqst_ready_i[c]`.
- Exclusive DRC1 means DRC1=1, DRC2=0 and DRC3=0 on that channel.
- Next-address rule on a handshake, applied in priority order:
  - If rebasing is enabled and the beat is exclusive DRC1, next = `ADDR_BASE+REBASE_OFFSET` and rebase_cnt increments.
  - Otherwise, if addr = `ADDR_BASE+ADDR_DEPTH-1`, next = `ADDR_BASE` (wrap).
  - Otherwise, next = addr+1.
- `incr_operand_o` = (next − addr) mod 2^ADDR_WIDTH, registered together with the new address.
- `is_drc_i` is ignored on cycles without a handshake on that channel.
- Backpressure: while valid is high and ready is low, the address, operand and counters hold.
- A channel drops valid after its `len`-th handshake and stays idle until the run ends.
- `scu_begin_i` during RUN restarts the run: all channels reload, no `done_o` is issued, and the new length is used.
- `scu_begin_i` during DONE is accepted and treated as starting from IDLE; `done_o` still pulses that cycle.
- `rebase_cnt_o` saturates at 2^LEN_WIDTH−1 and holds its value until the next `scu_begin_i`.

## Timing
- All outputs are registered. Reset values are:
  - `rqst_valid_o`, `busy_o`, `done_o`: 0
  - `rqst_addr_o`: `ADDR_BASE`
  - `incr_operand_o`, `rebase_cnt_o`: 0
  - state: IDLE
- `scu_begin_i` at cycle t gives valid=1 and addr=`ADDR_BASE` at t+1.
- With ready held high, one beat is accepted per cycle. A handshake at cycle k presents the next address at k+1.
- If the last handshake of the last channel occurs at cycle k, then at k+1 state is DONE, `done_o`=1 and `busy_o`=0.
- A zero-length run gives `done_o` at t+1 and no valids.
- `rst` asserted mid-run forces the reset values on the next edge; no `done_o` is issued.

## Structure
- `memShare_config_pkg` holds:
  - `MEMSHARE_DRC_NUM` and the DRC1/DRC2/DRC3 index constants
  - the FSM state enum typedef
  - the exclusive-DRC1 check as a function
- Sub-module `memshare_rqst_addr_lane` implements one channel: address, operand, beat and rebase counters, and valid. It is instantiated `CH_NUM` times by generate.
- The top level holds the FSM and the all-channels-done reduction.

## Test plan
- Reset: hold `rst` for 2 cycles, then release. All outputs equal their reset values and `done_o` never pulses.
- Linear run: len=5, all ready=1, no DRC, begin at t. Every channel gives addr 0,1,2,3,4 at t+1..t+5 with operands 0,1,1,1,1. `done_o` pulses at t+6.
- Rebase: len=4, rebase_en=1, ch0 DRC=3'b001 on the beat with addr 1.
  - ch0 gives addrs 0,1,16,17 with operands 0,1,15,1 and rebase_cnt=1.
  - ch1–3 give addrs 0..3.
- Non-exclusive DRC and rebase disabled:
  - ch0 DRC=3'b011 on the addr-1 beat gives addr 2.
  - rebase_en=0 with 3'b001 gives addr 2.
  - rebase_cnt stays 0 in both cases.
- Wrap and backpressure: len=50, ch1 ready toggling 1/0.
  - addr holds during ready=0.
  - After addr 47, next is addr 0 with operand (0−47) mod 64 = 17.
  - `done_o` pulses only after ch1's 50th handshake.
- Restart and reset mid-run:
  - `scu_begin_i` at beat 3 with len=2 reloads addr 0 and clears the counters; `done_o` pulses after 2 further beats.
  - `rst` asserted at beat 3 instead gives reset values and no `done_o`.
